nibble_exec: RTL and testbench



---
 rtl/nibble_exec_pkg.sv | 34 +++
 rtl/nibble_alu.sv | 68 ++++++
 rtl/nibble_exec.sv | 126 ++++++++++++
 tb/tb_nibble_exec.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_exec_pkg.sv
// Shared definitions for the nibble processor decode/execute stage: opcode map,
// sequencer state encoding and default widths.
`timescale 1ns/1ps
package nibble_exec_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 12;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // Bit positions inside the ALU flag write-enable vector.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_alu.sv
// Combinational ALU of the nibble processor: computes the accumulator result,
// carry/zero flags and which of them the current opcode writes.
`timescale 1ns/1ps
module nibble_alu
  import nibble_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] oprnd,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out,
  output logic              writes_acc,
  output logic [1:0]        writes_flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, oprnd};
  assign diff = {1'b0, acc} - {1'b0, oprnd};

  always_comb begin
    result       = acc;
    c_out        = 1'b0;
    writes_acc   = 1'b0;
    writes_flags = 2'b00;
    case (opcode)
      OP_LIT: begin
        result     = oprnd;
        writes_acc = 1'b1;
      end
      OP_ADDI: begin
        result       = sum[DATA_W-1:0];
        c_out        = sum[DATA_W];
        writes_acc   = 1'b1;
        writes_flags = 2'b11;
      end
      OP_SUBI: begin
        result       = diff[DATA_W-1:0];
        c_out        = ~diff[DATA_W];
        writes_acc   = 1'b1;
        writes_flags = 2'b11;
      end
      OP_NANDI: begin
        result               = ~(acc & oprnd);
        writes_acc           = 1'b1;
        writes_flags[FLAG_Z] = 1'b1;
      end
      OP_CMPI: begin
        result       = diff[DATA_W-1:0];
        c_out        = ~diff[DATA_W];
        writes_flags = 2'b11;
      end
      // The top routes in_port onto oprnd for IN.
      OP_IN: begin
        result               = oprnd;
        writes_acc           = 1'b1;
        writes_flags[FLAG_Z] = 1'b1;
      end
      default: ;
    endcase
    z_out = (result == '0);
  end

endmodule

// File: rtl/nibble_exec.sv
// Decode/execute stage and 2-cycle fetch/execute sequencer of the nibble processor.
// Optional HALT opcode enabled by defining NIBBLE_EXEC_HALT_EN.
`timescale 1ns/1ps
module nibble_exec
  import nibble_exec_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              R,
  input  logic [3:0]        instr,
  input  logic [DATA_W-1:0] oprnd,
  input  logic [7:0]        rom_data,
  input  logic [DATA_W-1:0] in_port,
  output logic              fetch_en,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              zero,
  output logic [DATA_W-1:0] out_port,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, out_q;
  logic              carry_q, zero_q;

  logic [DATA_W-1:0] alu_oprnd, alu_result;
  logic              alu_c, alu_z, alu_wa;
  logic [1:0]        alu_wf;
  logic              is_jump, jump_take, exec;
  logic [DATA_W+7:0] target_raw;

  assign alu_oprnd = (instr == OP_IN) ? in_port : oprnd;

  nibble_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .acc          (acc_q),
    .oprnd        (alu_oprnd),
    .opcode       (instr),
    .result       (alu_result),
    .c_out        (alu_c),
    .z_out        (alu_z),
    .writes_acc   (alu_wa),
    .writes_flags (alu_wf)
  );

  assign target_raw = {oprnd, rom_data};
  assign pc_target  = ADDR_W'(target_raw);

  // Conditions look at flags from before this instruction.
  always_comb begin
    is_jump   = 1'b1;
    jump_take = 1'b0;
    case (instr)
      OP_JMP:  jump_take = 1'b1;
      OP_JC:   jump_take = carry_q;
      OP_JNC:  jump_take = ~carry_q;
      OP_JZ:   jump_take = zero_q;
      OP_JNZ:  jump_take = ~zero_q;
      default: is_jump   = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    fetch_en = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    case (state_q)
      StFetch: begin
        fetch_en = 1'b1;
        pc_inc   = 1'b1;
        state_d  = StExec;
      end
      StExec: begin
        state_d = StFetch;
        if (is_jump) begin
          pc_load = jump_take;
          pc_inc  = ~jump_take;
        end
`ifdef NIBBLE_EXEC_HALT_EN
        if (instr == OP_HLT) state_d = StHalt;
`endif
      end
`ifdef NIBBLE_EXEC_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
  end

  assign exec = (state_q == StExec);

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q <= StFetch;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (exec && alu_wa)         acc_q   <= alu_result;
      if (exec && alu_wf[FLAG_C]) carry_q <= alu_c;
      if (exec && alu_wf[FLAG_Z]) zero_q  <= alu_z;
      if (exec && instr == OP_OUT) out_q  <= acc_q;
    end
  end

  assign acc      = acc_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign out_port = out_q;

`ifdef NIBBLE_EXEC_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_exec.sv
// Directed self-checking bench for nibble_exec; expected values computed by hand.
`timescale 1ns/1ps
module tb_nibble_exec;

  logic        CLK = 1'b0;
  logic        R = 1'b1;
  logic [3:0]  instr = 4'h0;
  logic [3:0]  oprnd = 4'h0;
  logic [7:0]  rom_data = 8'h00;
  logic [3:0]  in_port = 4'h0;
  logic        fetch_en, pc_inc, pc_load, carry, zero, halted;
  logic [11:0] pc_target;
  logic [3:0]  acc, out_port;

  int tests = 0;
  int fails = 0;

  nibble_exec #(
    .ADDR_W(12),
    .DATA_W(4)
  ) dut (
    .CLK       (CLK),
    .R         (R),
    .instr     (instr),
    .oprnd     (oprnd),
    .rom_data  (rom_data),
    .in_port   (in_port),
    .fetch_en  (fetch_en),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .acc       (acc),
    .carry     (carry),
    .zero      (zero),
    .out_port  (out_port),
    .halted    (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present an instruction in FETCH and advance to EXEC.
  task automatic issue(input logic [3:0] op, input logic [3:0] opr);
    instr = op;
    oprnd = opr;
    tick();
  endtask

  initial begin
    #100000;
    tests++;
    fails++;
    $error("FAIL watchdog: stimulus did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    tick();
    tick();
    check("rst_acc", acc, 4'h0);
    check("rst_c", carry, 1'b0);
    check("rst_z", zero, 1'b0);
    check("rst_out", out_port, 4'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_fetch_en", fetch_en, 1'b1);
    check("rst_pc_inc", pc_inc, 1'b1);
    check("rst_pc_load", pc_load, 1'b0);
    R = 1'b0;

    // LIT 9; ADDI 8; SUBI 1
    issue(4'h1, 4'h9);
    check("lit_exec_fetch_en", fetch_en, 1'b0);
    check("lit_exec_pc_inc", pc_inc, 1'b0);
    check("lit_exec_pc_load", pc_load, 1'b0);
    tick();
    check("lit_acc", acc, 4'h9);
    check("fetch_after_exec", fetch_en, 1'b1);
    issue(4'h2, 4'h8); tick();
    check("addi_acc", acc, 4'h1);
    check("addi_c", carry, 1'b1);
    check("addi_z", zero, 1'b0);
    issue(4'h3, 4'h1); tick();
    check("subi_acc", acc, 4'h0);
    check("subi_c", carry, 1'b1);
    check("subi_z", zero, 1'b1);

    // Reset asserted mid-EXEC with non-zero state
    issue(4'h1, 4'h7); tick();
    issue(4'h7, 4'h0); tick();
    check("pre_rst_out", out_port, 4'h7);
    issue(4'h1, 4'h3);
    R = 1'b1;
    #1;
    check("midrst_acc", acc, 4'h0);
    check("midrst_c", carry, 1'b0);
    check("midrst_z", zero, 1'b0);
    check("midrst_out", out_port, 4'h0);
    check("midrst_fetch_en", fetch_en, 1'b1);
    check("midrst_pc_inc", pc_inc, 1'b1);
    tick();
    R = 1'b0;
    #1;
    check("post_rst_fetch_en", fetch_en, 1'b1);

    // CMPI then jumps
    issue(4'h1, 4'h3); tick();
    issue(4'h5, 4'h5); tick();
    check("cmpi_acc", acc, 4'h3);
    check("cmpi_c", carry, 1'b0);
    check("cmpi_z", zero, 1'b0);
    rom_data = 8'h5C;
    issue(4'hA, 4'hA);
    check("jnc_load", pc_load, 1'b1);
    check("jnc_inc", pc_inc, 1'b0);
    check("jnc_target", pc_target, 12'hA5C);
    tick();
    rom_data = 8'h23;
    issue(4'hB, 4'h1);
    check("jz_nt_load", pc_load, 1'b0);
    check("jz_nt_inc", pc_inc, 1'b1);
    tick();
    issue(4'h9, 4'h1);
    check("jc_nt_load", pc_load, 1'b0);
    check("jc_nt_inc", pc_inc, 1'b1);
    tick();
    issue(4'hC, 4'h2);
    check("jnz_load", pc_load, 1'b1);
    check("jnz_target", pc_target, 12'h223);
    tick();
    rom_data = 8'h56;
    issue(4'h8, 4'h4);
    check("jmp_load", pc_load, 1'b1);
    check("jmp_inc", pc_inc, 1'b0);
    check("jmp_target", pc_target, 12'h456);
    tick();
    check("jmp_acc_kept", acc, 4'h3);

    // IN / OUT / NANDI
    in_port = 4'hE;
    issue(4'h6, 4'h0); tick();
    check("in_acc", acc, 4'hE);
    issue(4'h7, 4'h0); tick();
    check("out_port", out_port, 4'hE);
    issue(4'h4, 4'hF); tick();
    check("nandi_acc", acc, 4'h1);
    check("nandi_z", zero, 1'b0);
    in_port = 4'h0;
    issue(4'h6, 4'h0); tick();
    check("in0_z", zero, 1'b1);
    issue(4'h1, 4'hF); tick();
    issue(4'h2, 4'h1); tick();
    check("addi_wrap_acc", acc, 4'h0);
    check("addi_wrap_c", carry, 1'b1);
    issue(4'h4, 4'h0); tick();
    check("nandi0_acc", acc, 4'hF);
    check("nandi_c_kept", carry, 1'b1);
    check("nandi0_z", zero, 1'b0);
    issue(4'hD, 4'h5); tick();
    check("nop_d_acc", acc, 4'hF);

    // Opcode F
    issue(4'hF, 4'h3); tick();
`ifdef NIBBLE_EXEC_HALT_EN
    instr = 4'h1;
    for (int i = 0; i < 20; i++) begin
      check("halt_flag", halted, 1'b1);
      check("halt_strobes", {fetch_en, pc_inc, pc_load}, 3'b000);
      tick();
    end
    check("halt_acc_frozen", acc, 4'hF);
    R = 1'b1;
    #1;
    check("halt_rst_flag", halted, 1'b0);
    check("halt_rst_acc", acc, 4'h0);
    tick();
    R = 1'b0;
    #1;
    check("halt_rst_fetch_en", fetch_en, 1'b1);
`else
    check("f_nop_halted", halted, 1'b0);
    check("f_nop_acc", acc, 4'hF);
    check("f_nop_fetch_en", fetch_en, 1'b1);
    issue(4'h1, 4'h6); tick();
    check("after_f_lit", acc, 4'h6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
